// File: rtl/pe_mac_lanes.sv
// pe_mac_lanes: weight-stationary multi-lane MAC processing element.
// Optional output saturation is enabled by defining PE_OUT_SATURATE_EN.
module pe_mac_lanes #(
    parameter int DATA_WIDTH   = 8,
    parameter int WEIGHT_WIDTH = 8,
    parameter int LANES        = 4,
    parameter int MAX_LEN      = 16,
    parameter int OUT_WIDTH    = 16
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic [$clog2(MAX_LEN):0]      cfg_len,
    input  logic                          w_load,
    input  logic [LANES*WEIGHT_WIDTH-1:0] w_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [LANES*DATA_WIDTH-1:0]   in_data,
    output logic [LANES*DATA_WIDTH-1:0]   pix_out,
    output logic                          pix_valid,
    output logic [OUT_WIDTH-1:0]          acc_out,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          sat,
    output logic                          busy
);

    localparam int ACC_WIDTH = DATA_WIDTH + WEIGHT_WIDTH
                             + $clog2(LANES) + $clog2(MAX_LEN) + 1;
    localparam int LEN_W     = $clog2(MAX_LEN) + 1;
    localparam int PW        = DATA_WIDTH + WEIGHT_WIDTH;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DRAIN,
        HOLD
    } state_t;

    state_t                        state;
    logic [LANES*WEIGHT_WIDTH-1:0] w_q;
    logic [LEN_W-1:0]              len_q;
    logic [LEN_W-1:0]              cnt_q;
    logic [LEN_W-1:0]              eff_len;
    logic                          drain_q;
    logic                          rdy_q;
    logic                          ov_q;
    logic                          accept;
    logic                          handshake;
    logic                          pv_q;
    (* use_dsp = "yes" *)
    logic [ACC_WIDTH-1:0]          prod_q;
    logic [ACC_WIDTH-1:0]          acc_q;
    logic [ACC_WIDTH-1:0]          lane_sum;
    logic [PW-1:0]                 lane_p [LANES];

    assign accept    = in_valid & rdy_q;
    assign handshake = ov_q & out_ready;
    assign in_ready  = rdy_q;
    assign out_valid = ov_q;
    assign busy      = (state != IDLE);

    // Clamp the requested run length into 1..MAX_LEN
    always_comb begin
        eff_len = cfg_len;
        if (cfg_len == '0)
            eff_len = LEN_W'(1);
        else if (cfg_len > LEN_W'(MAX_LEN))
            eff_len = LEN_W'(MAX_LEN);
    end

    // Run control: beat counting, drain delay and result handshake
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= IDLE;
            len_q   <= '0;
            cnt_q   <= '0;
            drain_q <= 1'b0;
            rdy_q   <= 1'b0;
            ov_q    <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    rdy_q <= 1'b1;
                    if (accept) begin
                        len_q   <= eff_len;
                        cnt_q   <= LEN_W'(1);
                        drain_q <= 1'b0;
                        if (eff_len == LEN_W'(1)) begin
                            state <= DRAIN;
                            rdy_q <= 1'b0;
                        end else begin
                            state <= ACCUM;
                        end
                    end
                end
                ACCUM: begin
                    if (accept) begin
                        if (cnt_q + LEN_W'(1) == len_q) begin
                            state   <= DRAIN;
                            rdy_q   <= 1'b0;
                            drain_q <= 1'b0;
                        end else begin
                            cnt_q <= cnt_q + LEN_W'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (drain_q) begin
                        state   <= HOLD;
                        ov_q    <= 1'b1;
                        drain_q <= 1'b0;
                    end else begin
                        drain_q <= 1'b1;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state <= IDLE;
                        ov_q  <= 1'b0;
                        rdy_q <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Weights only change while no run is in flight
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            w_q <= '0;
        else if (w_load && state == IDLE)
            w_q <= w_data;
    end

    // Pixel forward register, also the first pipeline stage
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pix_out   <= '0;
            pix_valid <= 1'b0;
        end else begin
            pix_out   <= accept ? in_data : '0;
            pix_valid <= accept;
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        assign lane_p[g] =
            PW'(pix_out[g*DATA_WIDTH +: DATA_WIDTH]) *
            PW'(w_q[g*WEIGHT_WIDTH +: WEIGHT_WIDTH]);
    end

    // Adder tree over all lane products
    always_comb begin
        lane_sum = '0;
        for (int i = 0; i < LANES; i++)
            lane_sum = lane_sum + ACC_WIDTH'(lane_p[i]);
    end

    // Product stage register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            prod_q <= '0;
            pv_q   <= 1'b0;
        end else begin
            prod_q <= pix_valid ? lane_sum : '0;
            pv_q   <= pix_valid;
        end
    end

    // Accumulator, cleared when the result is taken
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            acc_q <= '0;
        else if (handshake)
            acc_q <= '0;
        else if (pv_q)
            acc_q <= acc_q + prod_q;
    end

`ifdef PE_OUT_SATURATE_EN
    localparam logic [ACC_WIDTH-1:0] OUT_MAX =
        ACC_WIDTH'({OUT_WIDTH{1'b1}});
    logic big;

    // Clip to the output range and flag it
    always_comb begin
        big     = (acc_q > OUT_MAX);
        acc_out = '0;
        sat     = 1'b0;
        if (ov_q) begin
            acc_out = big ? {OUT_WIDTH{1'b1}} : acc_q[OUT_WIDTH-1:0];
            sat     = big;
        end
    end
`else
    if (ACC_WIDTH > OUT_WIDTH) begin : g_hi
        logic acc_hi_unused;
        assign acc_hi_unused = ^acc_q[ACC_WIDTH-1:OUT_WIDTH];
    end

    // Wrap to the output width
    always_comb begin
        acc_out = ov_q ? acc_q[OUT_WIDTH-1:0] : '0;
        sat     = 1'b0;
    end
`endif

endmodule

// File: tb/tb_pe_mac_lanes.sv
// tb_pe_mac_lanes: directed and randomized checks of pe_mac_lanes
// against a dot-product reference model.
module tb_pe_mac_lanes;

    logic        clk = 1'b0;
    logic        rstn;
    logic [4:0]  cfg_len;
    logic        w_load;
    logic [31:0] w_data;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [31:0] pix_out;
    logic        pix_valid;
    logic [15:0] acc_out;
    logic        out_valid;
    logic        out_ready;
    logic        sat;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    logic [31:0] wm;
    logic [15:0] res;
    logic        sres;

    pe_mac_lanes dut (
        .clk       (clk),
        .rstn      (rstn),
        .cfg_len   (cfg_len),
        .w_load    (w_load),
        .w_data    (w_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .pix_out   (pix_out),
        .pix_valid (pix_valid),
        .acc_out   (acc_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sat       (sat),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag,
                         input logic [63:0] obs,
                         input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic longint dot(input logic [31:0] p,
                                   input logic [31:0] w);
        longint s = 0;
        for (int i = 0; i < 4; i++)
            s += longint'(p[8*i +: 8]) * longint'(w[8*i +: 8]);
        return s;
    endfunction

    function automatic longint out_of(input longint a);
`ifdef PE_OUT_SATURATE_EN
        return (a > 65535) ? 65535 : a;
`else
        return a % 65536;
`endif
    endfunction

    function automatic bit sat_of(input longint a);
`ifdef PE_OUT_SATURATE_EN
        return a > 65535;
`else
        return (a < 0);
`endif
    endfunction

    task automatic load_w(input logic [31:0] v);
        w_load = 1'b1;
        w_data = v;
        tick();
        w_load = 1'b0;
        wm     = v;
    endtask

    task automatic run(input int cfg, input int pmode, input int pval,
                       input int gap_at, input int pgap, input int bp,
                       input bit wl_first, input bit wl_mid,
                       input string tag,
                       output logic [15:0] r, output logic rs);
        int          L;
        int          b;
        int          lat;
        longint      acc;
        logic [31:0] pv;
        logic [7:0]  bv;
        L   = (cfg == 0) ? 1 : ((cfg > 16) ? 16 : cfg);
        acc = 0;
        b   = 0;
        cfg_len = 5'(cfg);
        while (b < L) begin
            bv = 8'(b + 1);
            if (pmode == 0)
                pv = $urandom;
            else if (pmode == 1)
                pv = {4{8'(pval)}};
            else
                pv = {4{bv}};
            in_data  = pv;
            in_valid = 1'b1;
            if (wl_first && b == 0) begin
                w_load = 1'b1;
                w_data = $urandom;
                wm     = w_data;
            end
            if (wl_mid && b == 1) begin
                w_load = 1'b1;
                w_data = ~wm;
            end
            check({tag, ":in_ready"}, in_ready, 1);
            tick();
            w_load = 1'b0;
            check({tag, ":pix_valid"}, pix_valid, 1);
            check({tag, ":pix_out"}, pix_out, pv);
            acc += dot(pv, wm);
            b++;
            if (b < L && (b - 1 == gap_at ||
                          int'($urandom_range(99)) < pgap)) begin
                in_valid = 1'b0;
                tick();
                check({tag, ":gap_pix"}, pix_valid, 0);
                check({tag, ":gap_busy"}, busy, 1);
            end
        end
        in_data = $urandom;
        check({tag, ":drain_rdy"}, in_ready, 0);
        check({tag, ":drain_ov"}, out_valid, 0);
        tick();
        check({tag, ":no_extra"}, pix_valid, 0);
        check({tag, ":drain_acc"}, acc_out, 0);
        lat = 1;
        while (!out_valid && lat < 8) begin
            tick();
            lat++;
        end
        in_valid = 1'b0;
        check({tag, ":latency"}, lat, 2);
        r  = acc_out;
        rs = sat;
        check({tag, ":acc"}, acc_out, out_of(acc));
        check({tag, ":sat"}, sat, sat_of(acc));
        out_ready = 1'b0;
        for (int i = 0; i < bp; i++) begin
            tick();
            check({tag, ":bp_ov"}, out_valid, 1);
            check({tag, ":bp_acc"}, acc_out, out_of(acc));
            check({tag, ":bp_rdy"}, in_ready, 0);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, ":post_ov"}, out_valid, 0);
        check({tag, ":post_acc"}, acc_out, 0);
        check({tag, ":post_busy"}, busy, 0);
        check({tag, ":post_rdy"}, in_ready, 1);
    endtask

    initial begin
        rstn      = 1'b0;
        cfg_len   = '0;
        w_load    = 1'b0;
        w_data    = '0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        wm        = '0;
        #12;
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_pix_valid", pix_valid, 0);
        check("rst_acc_out", acc_out, 0);
        check("rst_busy", busy, 0);
        check("rst_sat", sat, 0);
        rstn = 1'b1;
        tick();
        check("rel_in_ready", in_ready, 1);

        load_w({8'd4, 8'd3, 8'd2, 8'd1});
        run(1, 1, 10, -1, 0, 0, 0, 0, "t1", res, sres);
        check("t1_value", res, 100);

        run(3, 2, 0, 1, 0, 5, 0, 0, "t2", res, sres);
        check("t2_value", res, 60);
        run(2, 0, 0, -1, 0, 0, 0, 0, "t3_next", res, sres);

        load_w(32'hFFFF_FFFF);
        run(16, 1, 255, -1, 0, 1, 0, 0, "t4", res, sres);
`ifdef PE_OUT_SATURATE_EN
        check("t4_value", res, 65535);
        check("t4_satflag", sres, 1);
`else
        check("t4_value", res, 32832);
        check("t4_satflag", sres, 0);
`endif

        load_w({8'd4, 8'd3, 8'd2, 8'd1});
        run(0, 0, 0, -1, 0, 0, 0, 0, "t5_len0", res, sres);
        run(31, 0, 0, -1, 20, 0, 0, 0, "t5_len31", res, sres);

        run(3, 0, 0, -1, 0, 0, 0, 1, "t6_wmid", res, sres);
        run(4, 0, 0, -1, 0, 0, 1, 0, "t6_wfirst", res, sres);

        for (int k = 0; k < 8; k++) begin
            load_w($urandom);
            run(int'($urandom_range(0, 20)), 0, 0, -1, 30,
                int'($urandom_range(0, 3)), 0, 0, "rand", res, sres);
        end

        load_w($urandom | 32'h0101_0101);
        cfg_len  = 5'd4;
        in_valid = 1'b1;
        in_data  = $urandom | 32'h0101_0101;
        tick();
        tick();
        check("mid_busy", busy, 1);
        rstn = 1'b0;
        #1;
        check("mid_rst_pix_valid", pix_valid, 0);
        check("mid_rst_pix_out", pix_out, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_in_ready", in_ready, 0);
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_acc", acc_out, 0);
        in_valid = 1'b0;
        #2;
        rstn = 1'b1;
        wm   = '0;
        tick();
        check("mid_rel_in_ready", in_ready, 1);
        run(2, 0, 0, -1, 0, 0, 0, 0, "mid_fresh", res, sres);
        check("mid_fresh_value", res, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
